division_unsigned_datapath: RTL and testbench

Restoring shift-subtract datapath for the unsigned divider. It sits directly downstream of `division_unsigned_control` and is driven by that controller's `start_i`, `reg_enable_o` and `ready_o`. It latches the operands, performs one quotient-bit step per enabled cycle, and publishes quotient and remainder with a one-cycle valid strobe. The controller must be instantiated with `g_counter_max = g_width` so that exactly `g_width` enable cycles occur per division.

---
 rtl/division_unsigned_datapath.sv | 120 ++++++++++++
 tb/tb_division_unsigned_datapath.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/division_unsigned_datapath.sv
// Restoring shift-subtract datapath for the unsigned divider, stepped by division_unsigned_control.
// Optional macro DIVISION_ZERO_CHECK_EN: flag divide-by-zero and force a zero quotient/remainder.
module division_unsigned_datapath #(
   parameter int unsigned g_width = 8
) (
   input  logic               clk_i,
   input  logic               res_n_i,
   input  logic               start_i,
   input  logic               reg_enable_i,
   input  logic               ready_i,
   input  logic [g_width-1:0] dividend_i,
   input  logic [g_width-1:0] divisor_i,
   output logic [g_width-1:0] quotient_o,
   output logic [g_width-1:0] remainder_o,
   output logic               result_valid_o,
   output logic               div_by_zero_o
);

   localparam int unsigned W = g_width;

   // The remainder carry bit never feeds the next step, so only W bits are stored.
   logic [W-1:0] rem_q, rem_d;
   logic [W-1:0] quo_q, quo_d;
   logic [W-1:0] divisor_q, divisor_d;
   logic [W-1:0] quotient_q, quotient_d;
   logic [W-1:0] remainder_q, remainder_d;
   logic         valid_q, valid_d;

   logic [W:0]   t_c;
   logic [W:0]   divisor_ext_c;
   logic         ge_c;

`ifdef DIVISION_ZERO_CHECK_EN
   logic         zero_q, zero_d;
   logic         dbz_q, dbz_d;
`endif

   assign t_c           = {rem_q, quo_q[W-1]};
   assign divisor_ext_c = {1'b0, divisor_q};
   assign ge_c          = (t_c >= divisor_ext_c);

   // Load, step and publish.
   always_comb begin
      rem_d       = rem_q;
      quo_d       = quo_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      valid_d     = 1'b0;
`ifdef DIVISION_ZERO_CHECK_EN
      zero_d      = zero_q;
      dbz_d       = dbz_q;
`endif

      if (reg_enable_i) begin
         rem_d = ge_c ? W'(t_c - divisor_ext_c) : t_c[W-1:0];
         quo_d = {quo_q[W-2:0], ge_c};
      end else if (start_i) begin
         quo_d     = dividend_i;
         divisor_d = divisor_i;
         rem_d     = '0;
`ifdef DIVISION_ZERO_CHECK_EN
         zero_d    = (divisor_i == '0);
`endif
      end

      // Publish reads the pre-edge working registers, so a same-edge load is safe.
      if (ready_i) begin
         valid_d     = 1'b1;
         quotient_d  = quo_q;
         remainder_d = rem_q;
`ifdef DIVISION_ZERO_CHECK_EN
         dbz_d       = zero_q;
         if (zero_q) begin
            quotient_d  = '0;
            remainder_d = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         rem_q       <= '0;
         quo_q       <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         valid_q     <= valid_d;
      end
   end

`ifdef DIVISION_ZERO_CHECK_EN
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         zero_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         dbz_q  <= dbz_d;
      end
   end

   assign div_by_zero_o = dbz_q;
`else
   assign div_by_zero_o = 1'b0;
`endif

   assign quotient_o     = quotient_q;
   assign remainder_o    = remainder_q;
   assign result_valid_o = valid_q;

endmodule

// File: tb/tb_division_unsigned_datapath.sv
// Scoreboard bench for division_unsigned_datapath; the bench plays the controller's role.
module tb_division_unsigned_datapath;

   localparam int unsigned W = 8;

   logic         clk_i = 1'b0;
   logic         res_n_i;
   logic         start_i;
   logic         reg_enable_i;
   logic         ready_i;
   logic [W-1:0] dividend_i;
   logic [W-1:0] divisor_i;
   logic [W-1:0] quotient_o;
   logic [W-1:0] remainder_o;
   logic         result_valid_o;
   logic         div_by_zero_o;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   tests    = 0;
   int   failures = 0;
   int   edge_cnt = 0;

   division_unsigned_datapath #(.g_width(W)) dut (
      .clk_i          (clk_i),
      .res_n_i        (res_n_i),
      .start_i        (start_i),
      .reg_enable_i   (reg_enable_i),
      .ready_i        (ready_i),
      .dividend_i     (dividend_i),
      .divisor_i      (divisor_i),
      .quotient_o     (quotient_o),
      .remainder_o    (remainder_o),
      .result_valid_o (result_valid_o),
      .div_by_zero_o  (div_by_zero_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid strobe must match the oldest outstanding expectation.
   always @(negedge clk_i) begin
      if (res_n_i === 1'b1 && result_valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency_edge", edge_cnt, e.due);
            chk("quotient", int'(quotient_o), int'(e.q));
            chk("remainder", int'(remainder_o), int'(e.r));
            chk("div_by_zero", int'(div_by_zero_o), int'(e.z));
         end
      end
   end

   task automatic cyc(input logic s, input logic e, input logic r,
                      input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk_i);
      start_i      = s;
      reg_enable_i = e;
      ready_i      = r;
      if (s) begin
         dividend_i = a;
         divisor_i  = b;
      end
   endtask

   // Called right after the loading cyc(); the load edge is edge_cnt+1.
   task automatic expect_res(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
      exp_t e;
      e.q   = q;
      e.r   = r;
      e.z   = z;
      e.due = edge_cnt + 1 + int'(W) + 1;
      sb.push_back(e);
   endtask

   task automatic enables(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic div(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
      cyc(1'b1, 1'b0, 1'b0, a, b);
      expect_res(q, r, z);
      enables(int'(W));
      cyc(1'b0, 1'b0, 1'b1, '0, '0);
      idle(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      res_n_i      = 1'b0;
      start_i      = 1'b0;
      reg_enable_i = 1'b0;
      ready_i      = 1'b0;
      dividend_i   = '0;
      divisor_i    = '0;
      repeat (3) @(negedge clk_i);
      chk("reset_quotient", int'(quotient_o), 0);
      chk("reset_remainder", int'(remainder_o), 0);
      chk("reset_valid", int'(result_valid_o), 0);
      chk("reset_dbz", int'(div_by_zero_o), 0);
      res_n_i = 1'b1;
      idle(2);

      div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
      div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
      div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
`ifdef DIVISION_ZERO_CHECK_EN
      div(8'd77, 8'd0, 8'd0, 8'd0, 1'b1);
`else
      div(8'd77, 8'd0, 8'd255, 8'd77, 1'b0);
`endif

      // Start re-asserted mid-division must be ignored.
      cyc(1'b1, 1'b0, 1'b0, 8'd200, 8'd13);
      expect_res(8'd15, 8'd5, 1'b0);
      enables(3);
      cyc(1'b1, 1'b1, 1'b0, 8'd3, 8'd1);
      enables(4);
      cyc(1'b0, 1'b0, 1'b1, '0, '0);
      idle(2);

      // Back-to-back: publish 200/13 while loading 9/2 on the same edge.
      cyc(1'b1, 1'b0, 1'b0, 8'd200, 8'd13);
      expect_res(8'd15, 8'd5, 1'b0);
      enables(int'(W));
      cyc(1'b1, 1'b0, 1'b1, 8'd9, 8'd2);
      expect_res(8'd4, 8'd1, 1'b0);
      enables(int'(W));
      cyc(1'b0, 1'b0, 1'b1, '0, '0);
      idle(2);

      // Asynchronous reset mid-division discards the result.
      cyc(1'b1, 1'b0, 1'b0, 8'd100, 8'd7);
      enables(3);
      @(posedge clk_i);
      #2;
      res_n_i      = 1'b0;
      start_i      = 1'b0;
      reg_enable_i = 1'b0;
      ready_i      = 1'b0;
      #1;
      chk("async_rst_quotient", int'(quotient_o), 0);
      chk("async_rst_remainder", int'(remainder_o), 0);
      chk("async_rst_valid", int'(result_valid_o), 0);
      chk("async_rst_dbz", int'(div_by_zero_o), 0);
      @(negedge clk_i);
      res_n_i = 1'b1;
      idle(12);
      div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

      idle(3);
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
